// File: rtl/pic_cpu_bus_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pic_cpu_bus_master_if
// Description : Host request/response handshake plus the 8080/8086-style bus
//               control lines between the CPU-side bus master and the PIC.
//               The bidirectional data bus Ds is a separate inout port.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_cpu_bus_master_if;
    // host request / response
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic       req_a0;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    // interrupt side
    logic       INT;
    logic       vec_valid;
    logic [7:0] vec_data;
    // bus control toward the PIC
    logic       CS_n;
    logic       RD_n;
    logic       WR_n;
    logic       INTA_n;
    logic       A0;

    // Bus master (the DUT)
    modport master (
        input  req_valid, req_wr, req_a0, req_wdata, INT,
        output req_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
        output CS_n, RD_n, WR_n, INTA_n, A0
    );

    // Host logic plus PIC model on the other side
    modport slave (
        output req_valid, req_wr, req_a0, req_wdata, INT,
        input  req_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
        input  CS_n, RD_n, WR_n, INTA_n, A0
    );
endinterface
`default_nettype wire

// File: rtl/pic_cpu_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pic_cpu_bus_master
// Description : CPU-side initiator for the PIC 8-bit data bus. Turns single
//               beat register read/write requests into timed CS_n/RD_n/WR_n/
//               A0/Ds bus cycles. With macro PIC_BUS_INTA_AUTO_EN defined it
//               also runs the two-pulse INTA_n acknowledge when INT is high
//               and returns the vector byte.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_cpu_bus_master #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int GAP_CYC   = 2
) (
    input  wire                  clk,
    input  wire                  reset,
    pic_cpu_bus_master_if.master bus,
    inout  wire  [7:0]           Ds
);

    // One shared down-counter covers every timed state, so it is sized from
    // the longest phase. It holds "cycles remaining minus one".
    localparam int c_MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_MAX_CD  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
`ifdef PIC_BUS_INTA_AUTO_EN
    localparam logic [c_CNT_W-1:0] c_GAP_LD   = c_CNT_W'(GAP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3
`ifdef PIC_BUS_INTA_AUTO_EN
        ,
        INTA1  = 3'd4,
        GAP    = 3'd5,
        INTA2  = 3'd6
`endif
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic                 r_wr_q, w_wr_d;
    logic                 r_a0_q, w_a0_d;
    logic [7:0]           r_wdata_q, w_wdata_d;
    logic                 r_rsp_valid_q, w_rsp_valid_d;
    logic [7:0]           r_rdata_q, w_rdata_d;

    logic                 w_cnt_done;
    logic [c_CNT_W-1:0]   w_cnt_dec;
    logic                 w_in_cycle;
    logic                 w_ds_oe;

    assign w_cnt_done = (r_cnt_q == '0);
    assign w_cnt_dec  = r_cnt_q - c_CNT_W'(1);

    // CS_n window spans SETUP, STROBE and HOLD; write data rides the same window
    assign w_in_cycle = (r_state_q == SETUP) || (r_state_q == STROBE) || (r_state_q == HOLD);
    assign w_ds_oe    = w_in_cycle && r_wr_q;

    assign Ds            = w_ds_oe ? r_wdata_q : 8'hzz;
    assign bus.CS_n      = ~w_in_cycle;
    assign bus.A0        = w_in_cycle & r_a0_q;
    assign bus.WR_n      = ~((r_state_q == STROBE) && r_wr_q);
    assign bus.RD_n      = ~((r_state_q == STROBE) && !r_wr_q);
    assign bus.rsp_valid = r_rsp_valid_q;
    assign bus.rsp_rdata = r_rdata_q;

`ifdef PIC_BUS_INTA_AUTO_EN
    logic       r_vec_valid_q, w_vec_valid_d;
    logic [7:0] r_vec_data_q, w_vec_data_d;

    // A pending interrupt wins over a host request, so hold the host off
    assign bus.req_ready = (r_state_q == IDLE) && !reset && !bus.INT;
    assign bus.INTA_n    = ~((r_state_q == INTA1) || (r_state_q == INTA2));
    assign bus.vec_valid = r_vec_valid_q;
    assign bus.vec_data  = r_vec_data_q;
`else
    logic w_unused_int;

    assign w_unused_int  = bus.INT;
    assign bus.req_ready = (r_state_q == IDLE) && !reset;
    assign bus.INTA_n    = 1'b1;
    assign bus.vec_valid = 1'b0;
    assign bus.vec_data  = 8'h00;
`endif

    // Next-state, counter reloads, request latching and data capture
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_wr_d        = r_wr_q;
        w_a0_d        = r_a0_q;
        w_wdata_d     = r_wdata_q;
        w_rsp_valid_d = 1'b0;
        w_rdata_d     = r_rdata_q;
`ifdef PIC_BUS_INTA_AUTO_EN
        w_vec_valid_d = 1'b0;
        w_vec_data_d  = r_vec_data_q;
`endif
        case (r_state_q)
            IDLE: begin
`ifdef PIC_BUS_INTA_AUTO_EN
                if (bus.INT) begin
                    w_state_d = INTA1;
                    w_cnt_d   = c_PULSE_LD;
                end else
`endif
                if (bus.req_valid) begin
                    w_wr_d    = bus.req_wr;
                    w_a0_d    = bus.req_a0;
                    w_wdata_d = bus.req_wdata;
                    w_state_d = SETUP;
                    w_cnt_d   = c_SETUP_LD;
                end
            end
            SETUP: begin
                if (w_cnt_done) begin
                    w_state_d = STROBE;
                    w_cnt_d   = c_PULSE_LD;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            STROBE: begin
                if (w_cnt_done) begin
                    w_state_d = HOLD;
                    w_cnt_d   = c_HOLD_LD;
                    if (!r_wr_q) begin
                        w_rdata_d = Ds;
                    end
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            HOLD: begin
                if (w_cnt_done) begin
                    w_state_d     = IDLE;
                    w_rsp_valid_d = 1'b1;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
`ifdef PIC_BUS_INTA_AUTO_EN
            INTA1: begin
                if (w_cnt_done) begin
                    w_state_d = GAP;
                    w_cnt_d   = c_GAP_LD;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            GAP: begin
                if (w_cnt_done) begin
                    w_state_d = INTA2;
                    w_cnt_d   = c_PULSE_LD;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
            INTA2: begin
                if (w_cnt_done) begin
                    w_state_d     = IDLE;
                    w_vec_valid_d = 1'b1;
                    w_vec_data_d  = Ds;
                end else begin
                    w_cnt_d = w_cnt_dec;
                end
            end
`endif
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any cycle without a response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_wr_q        <= 1'b0;
            r_a0_q        <= 1'b0;
            r_wdata_q     <= 8'h00;
            r_rsp_valid_q <= 1'b0;
            r_rdata_q     <= 8'h00;
`ifdef PIC_BUS_INTA_AUTO_EN
            r_vec_valid_q <= 1'b0;
            r_vec_data_q  <= 8'h00;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_wr_q        <= w_wr_d;
            r_a0_q        <= w_a0_d;
            r_wdata_q     <= w_wdata_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rdata_q     <= w_rdata_d;
`ifdef PIC_BUS_INTA_AUTO_EN
            r_vec_valid_q <= w_vec_valid_d;
            r_vec_data_q  <= w_vec_data_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pic_cpu_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pic_cpu_bus_master
// Description : Self-checking bench for pic_cpu_bus_master. A transaction
//               level model expands each accepted request or INTA sequence
//               into the expected per-cycle bus picture; a simple PIC
//               responder drives Ds during RD_n / INTA_n pulses.
//               Honours PIC_BUS_INTA_AUTO_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_cpu_bus_master;

    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;
    localparam int HOLD_CYC  = 1;
    localparam int GAP_CYC   = 2;
`ifdef PIC_BUS_INTA_AUTO_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] Ds;

    pic_cpu_bus_master_if bus ();

    pic_cpu_bus_master #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .Ds    (Ds)
    );

    always #5 clk = ~clk;

    // ---------------- PIC responder ----------------
    logic [7:0] r_rd_val  = 8'h00;
    logic [7:0] r_vec_val = 8'h00;
    logic       r_inta_prev  = 1'b1;
    logic       r_inta_phase = 1'b0;

    // phase goes high once the first INTA pulse has ended
    always @(posedge clk) begin
        if (reset || bus.vec_valid) r_inta_phase <= 1'b0;
        else if (!r_inta_prev && bus.INTA_n) r_inta_phase <= 1'b1;
        r_inta_prev <= bus.INTA_n;
    end

    assign Ds = (bus.RD_n === 1'b0)   ? r_rd_val :
                (bus.INTA_n === 1'b0) ? (r_inta_phase ? r_vec_val : 8'h5A) : 8'hzz;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] kind;      // 0 idle, 1 bus cycle, 2 INTA sequence
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       inta_n;
        logic       a0;
        logic       ds_drv;
        logic [7:0] ds_val;
        logic       cap_rd;
        logic       cap_vec;
        logic       last_rsp;
        logic       last_vec;
        logic [7:0] data;
    } beat_t;

    beat_t      q[$];
    beat_t      cur;
    logic       e_rsp, e_vec;
    logic [7:0] e_rdata, e_vdata;
    bit         model_valid;
    bit         last_accept;
    logic       obs_rsp, obs_vec, obs_cs_low, obs_st_low, obs_inta_low, obs_ready;
    logic [7:0] obs_rdata, obs_vdata;
    int         n_cmp, n_fail;

    function automatic beat_t idle_beat();
        beat_t b;
        b        = '0;
        b.cs_n   = 1'b1;
        b.rd_n   = 1'b1;
        b.wr_n   = 1'b1;
        b.inta_n = 1'b1;
        return b;
    endfunction

    function automatic void push_bus(logic wr, logic a0, logic [7:0] wd, logic [7:0] rv);
        beat_t b;
        b        = idle_beat();
        b.kind   = 2'd1;
        b.cs_n   = 1'b0;
        b.a0     = a0;
        b.ds_drv = wr;
        b.ds_val = wd;
        for (int i = 0; i < SETUP_CYC; i++) q.push_back(b);
        for (int i = 0; i < PULSE_CYC; i++) begin
            beat_t s;
            s      = b;
            s.rd_n = wr;
            s.wr_n = !wr;
            if (i == PULSE_CYC - 1) begin
                s.cap_rd = !wr;
                s.data   = rv;
            end
            q.push_back(s);
        end
        for (int i = 0; i < HOLD_CYC; i++) begin
            beat_t h;
            h          = b;
            h.last_rsp = (i == HOLD_CYC - 1);
            q.push_back(h);
        end
    endfunction

    function automatic void push_inta(logic [7:0] v);
        beat_t b;
        b        = idle_beat();
        b.kind   = 2'd2;
        for (int i = 0; i < PULSE_CYC; i++) begin
            beat_t p;
            p        = b;
            p.inta_n = 1'b0;
            q.push_back(p);
        end
        for (int i = 0; i < GAP_CYC; i++) q.push_back(b);
        for (int i = 0; i < PULSE_CYC; i++) begin
            beat_t p;
            p        = b;
            p.inta_n = 1'b0;
            if (i == PULSE_CYC - 1) begin
                p.cap_vec  = 1'b1;
                p.last_vec = 1'b1;
                p.data     = v;
            end
            q.push_back(p);
        end
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        bit   acc, itk;
        logic exp_ready;
        #1;
        obs_rsp      = bus.rsp_valid;
        obs_vec      = bus.vec_valid;
        obs_cs_low   = !bus.CS_n;
        obs_st_low   = !bus.RD_n || !bus.WR_n;
        obs_inta_low = !bus.INTA_n;
        obs_ready    = bus.req_ready;
        obs_rdata    = bus.rsp_rdata;
        obs_vdata    = bus.vec_data;
        if (model_valid) begin
            exp_ready = (cur.kind == 2'd0) && !reset && !(c_AUTO && bus.INT);
            chk_b("CS_n", bus.CS_n, cur.cs_n);
            chk_b("RD_n", bus.RD_n, cur.rd_n);
            chk_b("WR_n", bus.WR_n, cur.wr_n);
            chk_b("INTA_n", bus.INTA_n, cur.inta_n);
            if (!cur.cs_n) chk_b("A0", bus.A0, cur.a0);
            if (cur.ds_drv) chk_v("Ds_wdata", Ds, cur.ds_val);
            else if (cur.rd_n && cur.inta_n) chk_v("Ds_released", Ds, 8'hzz);
            chk_b("req_ready", bus.req_ready, exp_ready);
            chk_b("rsp_valid", bus.rsp_valid, e_rsp);
            chk_v("rsp_rdata", bus.rsp_rdata, e_rdata);
            chk_b("vec_valid", bus.vec_valid, e_vec);
            chk_v("vec_data", bus.vec_data, e_vdata);
        end
        itk = c_AUTO && (bus.INT == 1'b1) && (cur.kind == 2'd0) && !reset;
        acc = !itk && (bus.req_valid == 1'b1) && (cur.kind == 2'd0) && !reset;
        @(posedge clk);
        if (reset) begin
            q.delete();
            cur         = idle_beat();
            e_rsp       = 1'b0;
            e_vec       = 1'b0;
            e_rdata     = 8'h00;
            e_vdata     = 8'h00;
            model_valid = 1'b1;
        end else begin
            e_rsp = cur.last_rsp;
            e_vec = cur.last_vec;
            if (cur.cap_rd)  e_rdata = cur.data;
            if (cur.cap_vec) e_vdata = cur.data;
            if (itk) push_inta(r_vec_val);
            else if (acc) push_bus(bus.req_wr, bus.req_a0, bus.req_wdata, r_rd_val);
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_beat();
        end
        last_accept = acc;
        #1;
    endtask

    // Run until a response pulse is observed (bounded)
    task automatic run_txn(output int lat, output int cs_low, output int st_low);
        lat    = 0;
        cs_low = 0;
        st_low = 0;
        do begin
            cycle();
            lat++;
            if (obs_cs_low) cs_low++;
            if (obs_st_low) st_low++;
        end while (!obs_rsp && lat < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cs_low, st_low, gap, cnt, inta_cyc, vec_cnt;
        logic [7:0] vdat;
        bit acc_seen, rsp_seen;

        n_cmp = 0; n_fail = 0; model_valid = 0; last_accept = 0;
        cur = idle_beat();
        e_rsp = 0; e_vec = 0; e_rdata = 8'h00; e_vdata = 8'h00;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_a0 = 1'b0;
        bus.req_wdata = 8'h00; bus.INT = 1'b0;

        // reset, then idle
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk_b("ready_first_cycle_after_reset", obs_ready, 1'b1);
        cycle();

        // write ICW1 0x13 to a0=0
        bus.req_wr = 1'b1; bus.req_a0 = 1'b0; bus.req_wdata = 8'h13; bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        run_txn(lat, cs_low, st_low);
        chk_i("wr_latency", lat, SETUP_CYC + PULSE_CYC + HOLD_CYC + 1);
        chk_i("wr_cs_low_cycles", cs_low, SETUP_CYC + PULSE_CYC + HOLD_CYC);
        chk_i("wr_strobe_cycles", st_low, PULSE_CYC);

        // read a0=1, PIC returns 0xA5
        r_rd_val = 8'hA5;
        bus.req_wr = 1'b0; bus.req_a0 = 1'b1; bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        run_txn(lat, cs_low, st_low);
        chk_i("rd_latency", lat, SETUP_CYC + PULSE_CYC + HOLD_CYC + 1);
        chk_v("rd_data_A5", obs_rdata, 8'hA5);

        // back-to-back: write 0xFF a0=1, then read a0=0
        bus.req_wr = 1'b1; bus.req_a0 = 1'b1; bus.req_wdata = 8'hFF; bus.req_valid = 1'b1;
        cycle();
        r_rd_val = 8'h3C;
        bus.req_wr = 1'b0; bus.req_a0 = 1'b0;
        gap = 0;
        do begin
            cycle();
            gap++;
        end while (!last_accept && gap < 20);
        chk_i("b2b_accept_spacing", gap, SETUP_CYC + PULSE_CYC + HOLD_CYC + 1);
        chk_b("b2b_rsp_in_accept_cycle", obs_rsp, 1'b1);
        bus.req_valid = 1'b0;
        run_txn(lat, cs_low, st_low);
        chk_v("b2b_rd_data", obs_rdata, 8'h3C);

        // reset during write STROBE aborts without a response
        bus.req_wr = 1'b1; bus.req_a0 = 1'b1; bus.req_wdata = 8'h77; bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        cnt = 0;
        while (cur.wr_n && cnt < 10) begin
            cycle();
            cnt++;
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk_b("abort_cs_n_high", obs_cs_low, 1'b0);
        chk_b("abort_wr_n_high", obs_st_low, 1'b0);
        cnt = obs_rsp ? 1 : 0;
        repeat (8) begin
            cycle();
            if (obs_rsp) cnt++;
        end
        chk_i("abort_no_rsp", cnt, 0);

        // INT together with a pending request
        r_vec_val = 8'h48;
        bus.INT = 1'b1;
        bus.req_wr = 1'b1; bus.req_a0 = 1'b0; bus.req_wdata = 8'h42; bus.req_valid = 1'b1;
        inta_cyc = 0; vec_cnt = 0; vdat = 8'h00; acc_seen = 0; rsp_seen = 0; cnt = 0;
        while (!rsp_seen && cnt < 60) begin
            cycle();
            cnt++;
            if (obs_inta_low) inta_cyc++;
            if (obs_vec) begin
                vec_cnt++;
                vdat = obs_vdata;
            end
            if (cur.kind == 2'd2) bus.INT = 1'b0;
            if (last_accept) begin
                bus.req_valid = 1'b0;
                acc_seen = 1;
            end
            if (acc_seen && obs_rsp) rsp_seen = 1;
        end
        bus.INT = 1'b0;
        chk_b("int_request_served", rsp_seen, 1'b1);
        chk_i("inta_low_cycles", inta_cyc, c_AUTO ? 2 * PULSE_CYC : 0);
        chk_i("vec_valid_pulses", vec_cnt, c_AUTO ? 1 : 0);
        chk_v("vec_data_48", vdat, c_AUTO ? 8'h48 : 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (cur.kind == 2'd0) begin
                r_rd_val  = 8'($urandom);
                r_vec_val = 8'($urandom);
                bus.INT   = ($urandom_range(0, 11) == 0);
            end else begin
                bus.INT = 1'b0;
            end
            if (!bus.req_valid && ($urandom_range(0, 2) == 0)) begin
                bus.req_valid = 1'b1;
                bus.req_wr    = 1'($urandom);
                bus.req_a0    = 1'($urandom);
                bus.req_wdata = 8'($urandom);
            end
            cycle();
            if (last_accept) bus.req_valid = 1'b0;
        end
        bus.INT = 1'b0;
        bus.req_valid = 1'b0;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
